weight_loader: RTL and testbench

- Downstream consumer of the weight FIFO filled by the AXI HP read path.
- Pops 16-bit words from that FIFO (standard read, 1-cycle dout latency) and assembles one K×K kernel plus an optional bias per output channel.
- Presents each assembled kernel in parallel to the convolution engine over a valid/ready handshake.
- Has a fill buffer and an output register, so the next kernel fills while the engine holds the current one.

---
 rtl/weight_loader.sv | 192 +++++++++++++++++++
 tb/tb_weight_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Pops weight words from the weight FIFO, assembles one K*K kernel (plus optional bias)
// per output channel in a fill buffer, and presents it over valid/ready from an output register.
module weight_loader #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned K        = 5,
    parameter int unsigned HAS_BIAS = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      kernel_count,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_W-1:0]     fifo_dout,
    output logic [K*K*DATA_W-1:0] kernel_data,
    output logic [DATA_W-1:0]     bias_data,
    output logic [CNT_W-1:0]      kernel_idx,
    output logic                  kernel_valid,
    input  logic                  kernel_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned KK    = K * K;
    localparam int unsigned WORDS = KK + HAS_BIAS;
    localparam int unsigned RC_W  = $clog2(WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_HOLD   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [RC_W-1:0]   req_cnt;
    logic [RC_W-1:0]   rcv_cnt;
    logic              rd_d1;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  fill_k;
    logic [CNT_W:0]    fill_k_inc;
    logic [DATA_W-1:0] fill_buf [WORDS];

    logic fill_full;
    logic out_free;
    logic more;
    logic handshake;
    logic accept;
    logic load;
    logic next_k;
    logic finish;

    assign fill_full  = (rcv_cnt == RC_W'(WORDS));
    assign out_free   = !kernel_valid || kernel_ready;
    assign handshake  = kernel_valid && kernel_ready;
    assign fill_k_inc = (CNT_W+1)'(fill_k) + (CNT_W+1)'(1);
    assign more       = (fill_k_inc < (CNT_W+1)'(count));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (kernel_count == '0) ? S_FINISH : S_FILL;
                end
            end
            S_FILL, S_HOLD: begin
                if (fill_full) begin
                    if (out_free) begin
                        state_nxt = more ? S_FILL : S_DRAIN;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                if (handshake) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode; reads are only issued while filling
    always_comb begin
        fifo_rd_en = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: accept = start;
            S_FILL: begin
                fifo_rd_en = (req_cnt < RC_W'(WORDS)) && !fifo_empty;
                load       = fill_full && out_free;
            end
            S_HOLD:   load   = fill_full && out_free;
            S_FINISH: finish = 1'b1;
            default: ;
        endcase
        next_k = load && more;
    end

    // Request/receive counters, kernel counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt <= '0;
            rcv_cnt <= '0;
            rd_d1   <= 1'b0;
            count   <= '0;
            fill_k  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            rd_d1 <= fifo_rd_en;
            done  <= finish;
            if (accept) begin
                busy    <= 1'b1;
                count   <= kernel_count;
                fill_k  <= '0;
                req_cnt <= '0;
                rcv_cnt <= '0;
            end else if (next_k) begin
                fill_k  <= fill_k + CNT_W'(1);
                req_cnt <= '0;
                rcv_cnt <= '0;
            end else begin
                if (fifo_rd_en) begin
                    req_cnt <= req_cnt + RC_W'(1);
                end
                if (rd_d1) begin
                    rcv_cnt <= rcv_cnt + RC_W'(1);
                end
            end
            if (finish) begin
                busy <= 1'b0;
            end
        end
    end

    // Fill buffer: FIFO data lands one cycle after its read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                fill_buf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (rd_d1 && (rcv_cnt == RC_W'(i))) begin
                    fill_buf[i] <= fifo_dout;
                end
            end
        end
    end

    // Output register: loaded when free or being consumed this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_valid <= 1'b0;
            kernel_data  <= '0;
            bias_data    <= '0;
            kernel_idx   <= '0;
        end else begin
            if (load) begin
                kernel_valid <= 1'b1;
                kernel_idx   <= fill_k;
                for (int unsigned i = 0; i < KK; i++) begin
                    kernel_data[i*DATA_W +: DATA_W] <= fill_buf[i];
                end
                bias_data <= (HAS_BIAS != 0) ? fill_buf[WORDS-1] : '0;
            end else if (handshake) begin
                kernel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: FIFO model, ready driver, handshake monitor and a
// queue-based reference that chunks the pushed word stream into kernels.
module tb_weight_loader;

    localparam int DW    = 16;
    localparam int KK    = 25;
    localparam int WORDS = 26;
    localparam int CW    = 8;
    localparam int KW    = KK * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] kernel_count;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic [KW-1:0] kernel_data;
    logic [DW-1:0] bias_data;
    logic [CW-1:0] kernel_idx;
    logic          kernel_valid;
    logic          kernel_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    weight_loader #(.DATA_W(16), .K(5), .HAS_BIAS(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .kernel_count(kernel_count),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .kernel_data(kernel_data), .bias_data(bias_data), .kernel_idx(kernel_idx),
        .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
        .busy(busy), .done(done)
    );

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [KW-1:0] got_data[$];
    logic [DW-1:0] got_bias[$];
    logic [CW-1:0] got_idx[$];

    int cyc = 0;
    int fmode = 0, rmode = 0, hold_left = 0, stall_left = 0, pops = 0;
    int rd_cnt = 0, underflow = 0, unstable = 0, valid_cycles = 0, done_cnt = 0;
    int done_cyc = -1, hs_cyc = -1, first_valid_cyc = -1, busy_rise_cyc = -1, start_cyc = 0;
    int total = 0, bad = 0;

    // Synchronous FIFO model with optional empty stalls
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            rd_cnt++;
            if (fifo_empty || fq.size() == 0) underflow++;
            else begin
                fifo_dout <= fq.pop_front();
                pops++;
            end
        end
        if (stall_left > 0) stall_left--;
        if (fmode == 2 && fifo_rd_en && !fifo_empty && (pops % 5) == 0) stall_left = 3;
        fifo_empty <= (fq.size() == 0) || (stall_left > 0) ||
                      (fmode == 1 && $urandom_range(0, 3) == 0);
    end

    // Engine ready: always, random, or held low for a number of valid cycles
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: kernel_ready = 1'b1;
            1: kernel_ready = 1'($urandom_range(0, 1));
            default: begin
                if (hold_left > 0) begin
                    kernel_ready = 1'b0;
                    if (kernel_valid) hold_left--;
                end else begin
                    kernel_ready = 1'b1;
                end
            end
        endcase
    end

    logic pv, pr, pbusy;
    logic [KW-1:0] pd;
    logic [DW-1:0] pb;
    logic [CW-1:0] pi;

    // Mid-cycle monitor: handshakes, done/busy timing, stability while stalled
    always @(negedge clk) begin
        if (!rst) begin
            if (kernel_valid && kernel_ready) begin
                got_data.push_back(kernel_data);
                got_bias.push_back(bias_data);
                got_idx.push_back(kernel_idx);
                hs_cyc = cyc;
            end
            if (kernel_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && !pbusy) busy_rise_cyc = cyc;
            if (pv && !pr && (!kernel_valid || kernel_data != pd || bias_data != pb || kernel_idx != pi))
                unstable++;
        end
        pv = kernel_valid; pr = kernel_ready; pd = kernel_data;
        pb = bias_data; pi = kernel_idx; pbusy = busy;
    end

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic chk_vec(input string name, input logic [KW-1:0] act, input logic [KW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic clear_stats();
        got_data.delete(); got_bias.delete(); got_idx.delete();
        rd_cnt = 0; underflow = 0; unstable = 0; valid_cycles = 0; done_cnt = 0; pops = 0;
        done_cyc = -1; hs_cyc = -1; first_valid_cyc = -1; busy_rise_cyc = -1;
    endtask

    // Load the FIFO (sequential or random words) and let the empty flag settle
    task automatic prep(input int nwords, input bit seq);
        fq.delete();
        exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            logic [DW-1:0] w;
            w = seq ? DW'(i) : DW'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int cnt);
        start = 1'b1;
        kernel_count = CW'(cnt);
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        kernel_count = CW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) chk("done timeout", 0, 1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Reference: kernel k is words k*WORDS .. k*WORDS+24 of the pushed stream, bias follows
    task automatic compare_model(input string tag, input int cnt);
        logic [KW-1:0] want;
        chk($sformatf("%s kernels", tag), got_data.size(), cnt);
        for (int k = 0; k < got_data.size() && k < cnt; k++) begin
            for (int i = 0; i < KK; i++) want[i*DW +: DW] = exp_q[k*WORDS + i];
            chk_vec($sformatf("%s data k%0d", tag, k), got_data[k], want);
            chk($sformatf("%s bias k%0d", tag, k), longint'(got_bias[k]), longint'(exp_q[k*WORDS + KK]));
            chk($sformatf("%s idx k%0d", tag, k), longint'(got_idx[k]), k);
        end
        chk($sformatf("%s reads", tag), rd_cnt, cnt * WORDS);
        chk($sformatf("%s underflow", tag), underflow, 0);
        chk($sformatf("%s unstable", tag), unstable, 0);
        chk($sformatf("%s done count", tag), done_cnt, 1);
        if (cnt > 0) chk($sformatf("%s done after hs", tag), done_cyc, hs_cyc + 2);
    endtask

    typedef struct {
        int cnt;
        int fmode;
        int rmode;
        int exp_reads;
        int hold_reads;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 26, -1};
        vecs[1] = '{3, 0, 2, 78, 52};
        vecs[2] = '{2, 2, 0, 52, -1};
        vecs[3] = '{0, 0, 0, 0, -1};
        vecs[4] = '{4, 1, 1, 104, -1};

        rst = 1'b1; start = 1'b0; kernel_count = '0; kernel_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset valid", kernel_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_en", fifo_rd_en, 0);
        chk_vec("reset data", kernel_data, '0);
        chk("reset idx", kernel_idx, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Preloaded 0x0000.. stream, single kernel, minimum latency
        clear_stats(); fmode = 0; rmode = 0;
        prep(WORDS + 3, 1'b1);
        do_start(1);
        wait_done(200);
        chk("latency", first_valid_cyc - start_cyc, WORDS + 2);
        chk("valid cycles", valid_cycles, 1);
        chk("seq kernels", got_data.size(), 1);
        if (got_data.size() > 0) begin
            chk("word0", longint'(got_data[0][15:0]), 0);
            chk("word24", longint'(got_data[0][24*DW +: DW]), 24);
            chk("bias", longint'(got_bias[0]), 25);
            chk("idx0", longint'(got_idx[0]), 0);
        end
        compare_model("seq", 1);

        // Table of runs
        for (int v = 0; v < 5; v++) begin
            clear_stats();
            fmode = vecs[v].fmode; rmode = vecs[v].rmode; hold_left = 40;
            prep(vecs[v].cnt * WORDS + 3, 1'b0);
            do_start(vecs[v].cnt);
            if (vecs[v].hold_reads >= 0) begin
                for (int n = 0; n < 300 && first_valid_cyc < 0; n++) @(negedge clk);
                repeat (35) @(negedge clk);
                chk($sformatf("vec%0d hold reads", v), rd_cnt, vecs[v].hold_reads);
                chk($sformatf("vec%0d hold kernels", v), got_data.size(), 0);
            end
            wait_done(3000);
            chk($sformatf("vec%0d table reads", v), rd_cnt, vecs[v].exp_reads);
            compare_model($sformatf("vec%0d", v), vecs[v].cnt);
            if (vecs[v].cnt == 0) begin
                chk("zero valid", valid_cycles, 0);
                chk("zero done timing", done_cyc, busy_rise_cyc + 1);
            end
        end

        // Randomized runs with random empty and random ready
        for (int r = 0; r < 4; r++) begin
            int c;
            c = $urandom_range(1, 3);
            clear_stats(); fmode = 1; rmode = 1;
            prep(c * WORDS + 3, 1'b0);
            do_start(c);
            wait_done(3000);
            compare_model($sformatf("rnd%0d", r), c);
        end

        // Second start while busy is ignored
        clear_stats(); fmode = 0; rmode = 0;
        prep(2 * WORDS + 30, 1'b0);
        do_start(2);
        repeat (10) @(posedge clk); #1;
        start = 1'b1; kernel_count = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1000);
        repeat (60) @(posedge clk); #1;
        compare_model("restart", 2);

        // Asynchronous reset while kernel 0 is held and kernel 1 is filling
        clear_stats(); fmode = 0; rmode = 2; hold_left = 1000;
        prep(2 * WORDS + 3, 1'b1);
        do_start(2);
        for (int n = 0; n < 300 && rd_cnt < WORDS + 10; n++) @(negedge clk);
        chk("pre-reset valid", kernel_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst valid", kernel_valid, 0);
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst rd_en", fifo_rd_en, 0);
        chk_vec("arst data", kernel_data, '0);
        chk("arst bias", bias_data, 0);
        chk("arst idx", kernel_idx, 0);
        fq.delete();
        rmode = 0; hold_left = 0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        clear_stats();
        prep(WORDS + 3, 1'b1);
        do_start(1);
        wait_done(300);
        compare_model("post-reset", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
